truth_table_sweep: RTL and testbench
====================================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL have parameter N, default 2, meaning the number of function inputs (legal range 1..6).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a request to begin a sweep.
REQ-005 SHALL have port hold, input, 1 bit, which pauses the sweep.
REQ-006 SHALL have port loop, input, 1 bit, which selects continuous sweeping.
REQ-007 SHALL have port tt, input, 2^N bits, the truth table; bit i is the function value for input vector i.
REQ-008 SHALL have port x, output, N bits, the current input vector (x[N-1] is the MSB).
REQ-009 SHALL have port s, output, 1 bit, the function value for x.
REQ-010 SHALL have port valid, output, 1 bit, qualifying x/s as a new evaluation this cycle.
REQ-011 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse at pass completion.
REQ-013 SHALL have port ones, output, N+1 bits, the count of s=1 over the last completed pass.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and FIN; all outputs registered.
REQ-015 SHALL, in IDLE with start=1 at an edge, latch tt into an internal table, enter RUN, and present x=0, s=table[0], valid=1 and busy=1 on the next cycle (1-cycle latency).
REQ-016 SHALL, in RUN with hold=0, advance x by 1 per cycle with s=table[x] and valid=1.
REQ-017 SHALL, in RUN with hold=1, keep x and s frozen, drive valid=0, and leave the accumulator unchanged; the sweep resumes at x+1 the cycle after hold falls.
REQ-018 SHALL accumulate s over every valid cycle of the pass in an N+1-bit counter; the maximum count of 2^N SHALL not overflow.
REQ-019 SHALL, at x=2^N-1 with hold=0 and loop=0, enter FIN next cycle: done=1, busy=0, valid=0, ones=final count; x and s hold their last values.
REQ-020 SHALL, at x=2^N-1 with hold=0 and loop=1, wrap x to 0 on the next cycle with no gap and stay in RUN. In that same cycle it SHALL pulse done=1, update ones, clear the accumulator, and count table[0] for the new pass.
REQ-021 SHALL return from FIN to IDLE unconditionally after one cycle; start SHALL be ignored in FIN and RUN.
REQ-022 SHALL ignore changes on tt after it has been latched; the next start re-latches tt.
REQ-023 SHALL, when loop falls mid-pass, complete the current pass and then enter FIN.
REQ-024 SHALL, when hold=1 at x=2^N-1, defer the wrap/FIN decision until hold falls, sampling loop at that edge.

Reset
REQ-025 SHALL, on rst_n=0, immediately (asynchronously) force IDLE and x=0, s=0, valid=0, busy=0, done=0, ones=0, accumulator=0, table=0.
REQ-026 SHALL, after rst_n rises, remain in IDLE until a start is sampled, including when reset occurred mid-sweep.

Verification (N=2 unless noted)
REQ-027 SHALL be verified by a reset scenario: rst_n=0 at any time -> all outputs 0 within the same cycle, busy=0.
REQ-028 SHALL be verified by a single-pass scenario: tt=4'b0011, start pulse -> x=0,1,2,3 on consecutive cycles with valid=1 and s=1,1,0,0; next cycle done=1, ones=2, busy=0; the following cycle is IDLE.
REQ-029 SHALL be verified by a hold scenario: same setup with hold=1 for 3 cycles while x=1 -> x stays 1 with valid=0 for 3 cycles, then x=2,3; done 7 cycles after the first valid.
REQ-030 SHALL be verified by a loop scenario: tt=4'b1111, loop=1 -> x=0,1,2,3,0,1,... with no gap; done=1 and ones=4 coincide with each x=0 after the first; dropping loop -> FIN after the current x=3.
REQ-031 SHALL be verified by a mid-operation scenario: rst_n low at x=2 -> outputs 0 at once; after release no activity until start. In a separate run, toggling tt and asserting start mid-sweep -> s sequence and timing unchanged.
REQ-032 SHALL be verified by a width scenario: N=3, tt=8'b1001_0110 (XOR3), start -> s=0,1,1,0,1,0,0,1 and ones=4.

Source files
------------

// File: rtl/truth_table_sweep.sv
// Purpose : sweeps every input vector of an N-input truth table, emitting x/s pairs and a ones count per pass.
// Latency : x=0 appears one cycle after start is sampled; done pulses the cycle after x=2^N-1 completes.
// Backpr. : hold=1 freezes x/s, drops valid and pauses counting; the sweep resumes at x+1 after hold falls.
//
// Ports
//   clk    - single clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin a sweep (honoured only in IDLE)
//   hold   - pause the sweep while in RUN
//   loop   - keep sweeping continuously, wrapping x to 0 after 2^N-1
//   tt     - truth table, bit i is the function value for input vector i
//   x      - current input vector (x[N-1] is the MSB)
//   s      - function value for x
//   valid  - x/s is a new evaluation this cycle
//   busy   - high while in RUN
//   done   - one-cycle pulse when a pass completes
//   ones   - number of s=1 evaluations in the last completed pass
module truth_table_sweep #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                hold,
    input  logic                loop,
    input  logic [(1<<N)-1:0]   tt,
    output logic [N-1:0]        x,
    output logic                s,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic [N:0]          ones
);

    localparam int DEPTH = 1 << N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Private copy of tt, so the table can change freely once a sweep starts.
    logic [DEPTH-1:0]   tbl;
    logic [DEPTH-1:0]   tbl_nxt;

    // Running ones count of the pass in progress. It already includes the s
    // currently on the outputs, so on the final step it is the pass total.
    // N+1 bits hold the worst case of 2^N without wrapping.
    logic [N:0]         acc;
    logic [N:0]         acc_nxt;

    logic [N-1:0]       x_nxt;
    logic               s_nxt;
    logic               valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [N:0]         ones_nxt;

    // Next vector in the sweep. At the last vector this wraps to 0 by itself,
    // which is exactly what the loop case wants.
    logic [N-1:0]       x_inc;
    logic               at_last;
    logic               nxt_bit;

    assign x_inc   = x + N'(1);
    assign at_last = (x == {N{1'b1}});
    assign nxt_bit = tbl[x_inc];

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        tbl_nxt   = tbl;
        acc_nxt   = acc;
        x_nxt     = x;
        s_nxt     = s;
        valid_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        ones_nxt  = ones;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    tbl_nxt   = tt;
                    x_nxt     = '0;
                    s_nxt     = tt[0];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    acc_nxt   = (N+1)'(tt[0]);
                end
            end

            RUN: begin
                busy_nxt = 1'b1;
                // With hold high everything stays put and valid drops. Note
                // that the end-of-pass decision is also parked here, so loop
                // is only looked at on the edge where hold is low.
                if (!hold) begin
                    if (at_last && !loop) begin
                        // Final vector already presented: close the pass.
                        // x and s keep the last evaluation.
                        state_nxt = FIN;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        ones_nxt  = acc;
                    end else begin
                        x_nxt     = x_inc;
                        s_nxt     = nxt_bit;
                        valid_nxt = 1'b1;
                        if (at_last) begin
                            // Seamless wrap: publish the finished pass and
                            // seed the new pass with the vector-0 value.
                            done_nxt = 1'b1;
                            ones_nxt = acc;
                            acc_nxt  = (N+1)'(nxt_bit);
                        end else begin
                            acc_nxt  = acc + (N+1)'(nxt_bit);
                        end
                    end
                end
            end

            FIN: begin
                // Single-cycle state; start is deliberately not looked at.
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl   <= '0;
            acc   <= '0;
            x     <= '0;
            s     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ones  <= '0;
        end else begin
            tbl   <= tbl_nxt;
            acc   <= acc_nxt;
            x     <= x_nxt;
            s     <= s_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            ones  <= ones_nxt;
        end
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, hold, loop;
    logic [3:0] tt2;
    logic [1:0] x2;
    logic       s2, valid2, busy2, done2;
    logic [2:0] ones2;

    logic       start3, hold3, loop3;
    logic [7:0] tt3;
    logic [2:0] x3;
    logic       s3, valid3, busy3, done3;
    logic [3:0] ones3;

    truth_table_sweep #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .loop(loop), .tt(tt2),
        .x(x2), .s(s2), .valid(valid2), .busy(busy2), .done(done2), .ones(ones2)
    );

    truth_table_sweep #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .hold(hold3), .loop(loop3), .tt(tt3),
        .x(x3), .s(s3), .valid(valid3), .busy(busy3), .done(done3), .ones(ones3)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] x;
        logic       s;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];
    exp_t e2, e3;

    typedef struct {
        logic [3:0] tt;
        logic [2:0] ones;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [3:0] t, input int i);
        exp_t e;
        e.x = 3'(i);
        e.s = t[i];
        q2.push_back(e);
    endtask

    // Scoreboards: every valid evaluation must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid2) begin
            if (q2.size() == 0) begin
                chk("dut2 valid with nothing expected", 32'(valid2), 32'(0));
            end else begin
                e2 = q2.pop_front();
                chk("dut2 x", 32'(x2), 32'(e2.x));
                chk("dut2 s", 32'(s2), 32'(e2.s));
            end
        end
        if (rst_n && valid3) begin
            if (q3.size() == 0) begin
                chk("dut3 valid with nothing expected", 32'(valid3), 32'(0));
            end else begin
                e3 = q3.pop_front();
                chk("dut3 x", 32'(x3), 32'(e3.x));
                chk("dut3 s", 32'(s3), 32'(e3.s));
            end
        end
    end

    // One non-looping pass; start and tt are churned after the latch to show
    // they are ignored in RUN and FIN.
    task automatic run_pass(input logic [3:0] t, input logic [2:0] exp_ones);
        tt2   = t;
        start = 1'b1;
        for (int i = 0; i < 4; i++) push2(t, i);
        step();
        chk("pass first valid", 32'(valid2), 32'(1));
        chk("pass first busy", 32'(busy2), 32'(1));
        for (int i = 1; i < 4; i++) begin
            tt2 = ~tt2;
            step();
            chk("pass valid", 32'(valid2), 32'(1));
            chk("pass no early done", 32'(done2), 32'(0));
        end
        step();
        chk("pass done", 32'(done2), 32'(1));
        chk("pass fin busy", 32'(busy2), 32'(0));
        chk("pass fin valid", 32'(valid2), 32'(0));
        chk("pass ones", 32'(ones2), 32'(exp_ones));
        chk("pass fin x held", 32'(x2), 32'(3));
        chk("pass fin s held", 32'(s2), 32'(t[3]));
        step();
        chk("idle after fin done", 32'(done2), 32'(0));
        chk("idle after fin busy", 32'(busy2), 32'(0));
        start = 1'b0;
        step();
        chk("start in fin ignored", 32'(busy2), 32'(0));
        chk("start in fin no valid", 32'(valid2), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] t;
        exp_t       e;

        vecs[0] = '{tt: 4'b0011, ones: 3'd2};
        vecs[1] = '{tt: 4'b0000, ones: 3'd0};
        vecs[2] = '{tt: 4'b1111, ones: 3'd4};
        vecs[3] = '{tt: 4'b1010, ones: 3'd2};
        vecs[4] = '{tt: 4'b0110, ones: 3'd2};
        vecs[5] = '{tt: 4'b1000, ones: 3'd1};

        rst_n = 1'b0; start = 1'b0; hold = 1'b0; loop = 1'b0; tt2 = '0;
        start3 = 1'b0; hold3 = 1'b0; loop3 = 1'b0; tt3 = '0;

        #1;
        chk("reset x", 32'(x2), 32'(0));
        chk("reset s", 32'(s2), 32'(0));
        chk("reset valid", 32'(valid2), 32'(0));
        chk("reset busy", 32'(busy2), 32'(0));
        chk("reset done", 32'(done2), 32'(0));
        chk("reset ones", 32'(ones2), 32'(0));
        chk("reset n3 busy", 32'(busy3), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("no activity without start", 32'(busy2), 32'(0));

        // Table-driven single passes.
        for (int v = 0; v < 6; v++) run_pass(vecs[v].tt, vecs[v].ones);

        // Hold for three cycles at x=1.
        t = 4'b0011; tt2 = t; start = 1'b1;
        for (int i = 0; i < 4; i++) push2(t, i);
        step();                                   // c1 x=0
        start = 1'b0;
        step();                                   // c2 x=1
        chk("hold pre x", 32'(x2), 32'(1));
        hold = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            step();
            chk("hold x frozen", 32'(x2), 32'(1));
            chk("hold valid low", 32'(valid2), 32'(0));
            chk("hold busy", 32'(busy2), 32'(1));
        end
        hold = 1'b0;
        step();                                   // c6 x=2
        chk("hold resume x", 32'(x2), 32'(2));
        step();                                   // c7 x=3
        chk("hold done not yet", 32'(done2), 32'(0));
        step();                                   // c8, 7 after first valid
        chk("hold done timing", 32'(done2), 32'(1));
        chk("hold ones", 32'(ones2), 32'(2));
        step();

        // Continuous looping, then dropping loop mid-pass.
        tt2 = 4'b1111; loop = 1'b1; start = 1'b1;
        for (int k = 0; k < 12; k++) push2(4'b1111, k % 4);
        step();                                   // c1
        start = 1'b0;
        chk("loop first no done", 32'(done2), 32'(0));
        for (int c = 2; c <= 12; c++) begin
            step();
            chk("loop valid no gap", 32'(valid2), 32'(1));
            chk("loop done at wrap", 32'(done2), 32'((c == 5) || (c == 9)));
            if (c == 5 || c == 9) chk("loop ones", 32'(ones2), 32'(4));
            if (c == 10) loop = 1'b0;
        end
        step();                                   // c13 FIN
        chk("loop drop done", 32'(done2), 32'(1));
        chk("loop drop valid", 32'(valid2), 32'(0));
        chk("loop drop busy", 32'(busy2), 32'(0));
        chk("loop drop x", 32'(x2), 32'(3));
        step();

        // Hold at the last vector: loop is decided on the edge hold falls.
        t = 4'b0101; tt2 = t; start = 1'b1;
        for (int k = 0; k < 8; k++) push2(t, k % 4);
        step();                                   // c1
        start = 1'b0;
        step(); step(); step();                   // c4 x=3
        chk("last hold pre x", 32'(x2), 32'(3));
        hold = 1'b1;
        step();                                   // c5 frozen
        chk("last hold valid", 32'(valid2), 32'(0));
        chk("last hold busy", 32'(busy2), 32'(1));
        chk("last hold no done", 32'(done2), 32'(0));
        hold = 1'b0; loop = 1'b1;
        step();                                   // c6 wrap
        chk("late loop wrap x", 32'(x2), 32'(0));
        chk("late loop done", 32'(done2), 32'(1));
        chk("late loop ones", 32'(ones2), 32'(2));
        loop = 1'b0;
        step(); step(); step();                   // c9 x=3
        step();                                   // c10 FIN
        chk("late loop fin done", 32'(done2), 32'(1));
        chk("late loop fin ones", 32'(ones2), 32'(2));
        step();

        // N=3 XOR3 sweep.
        tt3 = 8'b1001_0110; start3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e.x = 3'(i);
            e.s = tt3[i];
            q3.push_back(e);
        end
        step();
        start3 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("n3 valid", 32'(valid3), 32'(1));
        end
        step();
        chk("n3 done", 32'(done3), 32'(1));
        chk("n3 ones", 32'(ones3), 32'(4));
        step();

        // Asynchronous reset in the middle of a sweep.
        t = 4'b0011; tt2 = t; start = 1'b1;
        for (int i = 0; i < 4; i++) push2(t, i);
        step();
        start = 1'b0;
        step(); step();                           // x=2
        chk("midrst pre x", 32'(x2), 32'(2));
        rst_n = 1'b0;
        #1;
        chk("midrst x", 32'(x2), 32'(0));
        chk("midrst valid", 32'(valid2), 32'(0));
        chk("midrst busy", 32'(busy2), 32'(0));
        chk("midrst ones", 32'(ones2), 32'(0));
        chk("midrst s", 32'(s2), 32'(0));
        q2.delete();
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post rst idle busy", 32'(busy2), 32'(0));
        chk("post rst idle valid", 32'(valid2), 32'(0));
        chk("post rst idle x", 32'(x2), 32'(0));

        chk("q2 drained", 32'(q2.size()), 32'(0));
        chk("q3 drained", 32'(q3.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
